// File: rtl/edge_evt_pkg.sv
// Shared types and constants for the edge event scheduler.
package edge_evt_pkg;

  localparam int N_DEFAULT = 8;
  localparam int EVT_CNT_W = 16;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } evt_state_t;

endpackage

// File: rtl/edge_event_scheduler_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above start,
// wrapping modulo N.
module rr_pick #(
  parameter int N   = 8,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] start,
  output logic           any,
  output logic [IDW-1:0] idx
);

  logic [IDW-1:0] j;

  // Walk offsets from far to near so the nearest hit is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = IDW'((int'(start) + k) % N);
      if (req[j]) begin
        any = 1'b1;
        idx = j;
      end
    end
  end

endmodule

// File: rtl/edge_event_scheduler.sv
// Per-bit any-edge detector that queues edges as pending events and offers
// them one at a time, round-robin, over a valid/ready handshake.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   IDLE  | nothing offered; picks from pending starting at rr_ptr
//   OFFER | evt_id/evt_rise offered; on accept loads next winner or idles
module edge_event_scheduler
  import edge_evt_pkg::*;
#(
  parameter int N   = N_DEFAULT,
  parameter int IDW = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         in,
  input  logic [N-1:0]         mask,
  input  logic [N-1:0]         ovf_clr,
  input  logic                 evt_ready,
  output logic                 evt_valid,
  output logic [IDW-1:0]       evt_id,
  output logic                 evt_rise,
  output logic [N-1:0]         pending,
  output logic [N-1:0]         overflow,
  output logic [EVT_CNT_W-1:0] evt_count
);

  evt_state_t           state, state_n;
  logic [N-1:0]         d_last;
  logic                 armed;
  logic [N-1:0]         pend_q;
  logic [N-1:0]         pol_q;
  logic [N-1:0]         ovf_q;
  logic [IDW-1:0]       rr_ptr;
  logic [IDW-1:0]       id_q, id_n;
  logic                 rise_q, rise_n;
  logic [EVT_CNT_W-1:0] cnt_q;

  logic [N-1:0]   edge_vec;
  logic [N-1:0]   id_oh;
  logic [N-1:0]   acc_oh;
  logic [N-1:0]   pol_upd;
  logic           accept;
  logic [IDW-1:0] next_start;
  logic           any_idle, any_b2b;
  logic [IDW-1:0] idx_idle, idx_b2b;

  assign edge_vec   = (in ^ d_last) & mask & {N{armed}};
  assign accept     = (state == OFFER) && evt_ready;
  assign id_oh      = N'(1) << id_q;
  assign acc_oh     = accept ? id_oh : '0;
  assign next_start = (id_q == IDW'(N - 1)) ? '0 : id_q + IDW'(1);
  // A new edge may overwrite polarity only when the slot is free or being
  // vacated this cycle; otherwise the first event wins.
  assign pol_upd    = edge_vec & (~pend_q | acc_oh);

  rr_pick #(.N(N), .IDW(IDW)) u_pick_idle (
    .req   (pend_q),
    .start (rr_ptr),
    .any   (any_idle),
    .idx   (idx_idle)
  );

  rr_pick #(.N(N), .IDW(IDW)) u_pick_b2b (
    .req   (pend_q & ~id_oh),
    .start (next_start),
    .any   (any_b2b),
    .idx   (idx_b2b)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      id_q   <= '0;
      rise_q <= 1'b0;
    end else begin
      state  <= state_n;
      id_q   <= id_n;
      rise_q <= rise_n;
    end
  end

  always_comb begin
    state_n   = state;
    id_n      = id_q;
    rise_n    = rise_q;
    evt_valid = 1'b0;
    case (state)
      IDLE: begin
        if (any_idle) begin
          state_n = OFFER;
          id_n    = idx_idle;
          rise_n  = pol_q[idx_idle];
        end
      end
      OFFER: begin
        evt_valid = 1'b1;
        if (evt_ready) begin
          if (any_b2b) begin
            id_n   = idx_b2b;
            rise_n = pol_q[idx_b2b];
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      d_last <= '0;
      armed  <= 1'b0;
      pend_q <= '0;
      pol_q  <= '0;
      ovf_q  <= '0;
      rr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      d_last <= in;
      armed  <= 1'b1;
      pend_q <= (pend_q & ~acc_oh) | edge_vec;
      pol_q  <= (pol_q & ~pol_upd) | (in & pol_upd);
      ovf_q  <= (ovf_q & ~ovf_clr) | (edge_vec & pend_q & ~acc_oh);
      if (accept) begin
        rr_ptr <= next_start;
        if (cnt_q != '1) cnt_q <= cnt_q + EVT_CNT_W'(1);
      end
    end
  end

  assign evt_id    = id_q;
  assign evt_rise  = rise_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;
  assign evt_count = cnt_q;

endmodule

// File: tb/tb_edge_event_scheduler.sv
// Bench for edge_event_scheduler: directed table, hand sequences, and a
// randomized run against a behavioural model.
module tb_edge_event_scheduler;
  import edge_evt_pkg::*;

  localparam int N   = 8;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   din;
  logic [N-1:0]   mask;
  logic [N-1:0]   ovf_clr;
  logic           ready;
  logic           evt_valid;
  logic [IDW-1:0] evt_id;
  logic           evt_rise;
  logic [N-1:0]   pending;
  logic [N-1:0]   overflow;
  logic [15:0]    evt_count;

  always #5 clk = ~clk;

  edge_event_scheduler #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .reset     (reset),
    .in        (din),
    .mask      (mask),
    .ovf_clr   (ovf_clr),
    .evt_ready (ready),
    .evt_valid (evt_valid),
    .evt_id    (evt_id),
    .evt_rise  (evt_rise),
    .pending   (pending),
    .overflow  (overflow),
    .evt_count (evt_count)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input bit v, input int id, input bit rise,
                            input logic [7:0] p, input logic [7:0] o, input int cnt);
    chk({tag, ".valid"}, 32'(evt_valid), 32'(v));
    if (v) begin
      chk({tag, ".id"}, 32'(evt_id), 32'(id));
      chk({tag, ".rise"}, 32'(evt_rise), 32'(rise));
    end
    chk({tag, ".pending"}, 32'(pending), 32'(p));
    chk({tag, ".overflow"}, 32'(overflow), 32'(o));
    chk({tag, ".count"}, 32'(evt_count), 32'(cnt));
  endtask

  task automatic do_reset(input logic [7:0] v);
    reset   = 1'b1;
    din     = v;
    mask    = 8'hFF;
    ovf_clr = 8'h00;
    ready   = 1'b0;
    tick();
    tick();
  endtask

  typedef struct {
    logic [7:0] din;
    logic [7:0] mask;
    logic       rdy;
    bit         v;
    int         id;
    bit         rise;
    logic [7:0] pend;
    int         cnt;
  } vec_t;

  vec_t tbl[13];

  // Behavioural model state
  bit       m_armed, m_offer, m_rise;
  bit [7:0] m_last, m_pend, m_pol, m_ovf;
  int       m_ptr, m_id, m_count;

  function automatic int find_from(input bit [7:0] v, input int s);
    for (int k = 0; k < N; k++)
      if (v[(s + k) % N]) return (s + k) % N;
    return -1;
  endfunction

  task automatic model_step(input bit rst, input bit [7:0] i_in, input bit [7:0] i_mask,
                            input bit [7:0] i_clr, input bit rdy);
    bit       acc, e, acc_i;
    bit [7:0] np, npol, novf, v;
    int       w;
    if (rst) begin
      m_armed = 0; m_offer = 0; m_rise = 0;
      m_last = 0; m_pend = 0; m_pol = 0; m_ovf = 0;
      m_ptr = 0; m_id = 0; m_count = 0;
      return;
    end
    acc  = m_offer && rdy;
    np   = m_pend;
    npol = m_pol;
    novf = m_ovf & ~i_clr;
    for (int i = 0; i < N; i++) begin
      e     = m_armed && i_mask[i] && (i_in[i] != m_last[i]);
      acc_i = acc && (m_id == i);
      if (e) begin
        if (!m_pend[i] || acc_i) begin
          np[i]   = 1'b1;
          npol[i] = i_in[i];
        end else begin
          novf[i] = 1'b1;
        end
      end else if (acc_i) begin
        np[i] = 1'b0;
      end
    end
    if (!m_offer) begin
      w = find_from(m_pend, m_ptr);
      if (w >= 0) begin
        m_offer = 1; m_id = w; m_rise = m_pol[w];
      end
    end else if (acc) begin
      m_ptr = (m_id + 1) % N;
      if (m_count < 65535) m_count++;
      v = m_pend;
      v[m_id] = 1'b0;
      w = find_from(v, m_ptr);
      if (w >= 0) begin
        m_id = w; m_rise = m_pol[w];
      end else begin
        m_offer = 0;
      end
    end
    m_pend  = np;
    m_pol   = npol;
    m_ovf   = novf;
    m_last  = i_in;
    m_armed = 1;
  endtask

  initial begin
    bit       r_rst;
    bit [7:0] flip;

    // fields: din, mask, rdy, valid, id, rise, pending, count
    tbl[0]  = '{8'hA5, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 8'hA5, 0};
    tbl[1]  = '{8'hA5, 8'hFF, 1'b1, 1'b1, 0, 1'b1, 8'hA5, 0};
    tbl[2]  = '{8'hA5, 8'hFF, 1'b1, 1'b1, 2, 1'b1, 8'hA4, 1};
    tbl[3]  = '{8'hA5, 8'hFF, 1'b1, 1'b1, 5, 1'b1, 8'hA0, 2};
    tbl[4]  = '{8'hA5, 8'hFF, 1'b1, 1'b1, 7, 1'b1, 8'h80, 3};
    tbl[5]  = '{8'hA5, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 8'h00, 4};
    tbl[6]  = '{8'h00, 8'hFF, 1'b0, 1'b0, 0, 1'b0, 8'hA5, 4};
    tbl[7]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 4};
    tbl[8]  = '{8'h00, 8'hFF, 1'b0, 1'b1, 0, 1'b0, 8'hA5, 4};
    tbl[9]  = '{8'h00, 8'hFF, 1'b1, 1'b1, 2, 1'b0, 8'hA4, 5};
    tbl[10] = '{8'h00, 8'hFF, 1'b1, 1'b1, 5, 1'b0, 8'hA0, 6};
    tbl[11] = '{8'h00, 8'hFF, 1'b1, 1'b1, 7, 1'b0, 8'h80, 7};
    tbl[12] = '{8'h00, 8'hFF, 1'b1, 1'b0, 0, 1'b0, 8'h00, 8};

    // Reset with all-high input: no events after arming
    do_reset(8'hFF);
    expect_out("reset", 0, 0, 0, 8'h00, 8'h00, 0);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      tick();
      expect_out("steady_ff", 0, 0, 0, 8'h00, 8'h00, 0);
    end

    // Single rising edge on bit 0
    do_reset(8'h00);
    reset = 1'b0;
    tick();
    din = 8'h01; ready = 1'b1;
    tick(); expect_out("single.edge", 0, 0, 0, 8'h01, 8'h00, 0);
    tick(); expect_out("single.offer", 1, 0, 1, 8'h01, 8'h00, 0);
    tick(); expect_out("single.done", 0, 0, 0, 8'h00, 8'h00, 1);

    // Burst A5 rising then falling with backpressure (table)
    do_reset(8'h00);
    reset = 1'b0;
    tick();
    for (int r = 0; r < 13; r++) begin
      din   = tbl[r].din;
      mask  = tbl[r].mask;
      ready = tbl[r].rdy;
      tick();
      expect_out($sformatf("tbl%0d", r), tbl[r].v, tbl[r].id, tbl[r].rise,
                 tbl[r].pend, 8'h00, tbl[r].cnt);
    end

    // Overflow: second edge while pending and not accepted
    do_reset(8'h00);
    reset = 1'b0;
    tick();
    din = 8'h08; ready = 1'b0;
    tick(); expect_out("ovf.pend", 0, 0, 0, 8'h08, 8'h00, 0);
    tick(); expect_out("ovf.offer", 1, 3, 1, 8'h08, 8'h00, 0);
    din = 8'h00;
    tick(); expect_out("ovf.set", 1, 3, 1, 8'h08, 8'h08, 0);
    tick(); expect_out("ovf.hold", 1, 3, 1, 8'h08, 8'h08, 0);
    ready = 1'b1;
    tick(); expect_out("ovf.accept", 0, 0, 0, 8'h00, 8'h08, 1);
    ready = 1'b0; ovf_clr = 8'h08;
    tick(); expect_out("ovf.clear", 0, 0, 0, 8'h00, 8'h00, 1);
    ovf_clr = 8'h00;

    // Replacement: edge on the offered bit in its accept cycle
    din = 8'h08;
    tick(); expect_out("repl.pend", 0, 0, 0, 8'h08, 8'h00, 1);
    tick(); expect_out("repl.offer", 1, 3, 1, 8'h08, 8'h00, 1);
    ready = 1'b1; din = 8'h00;
    tick(); expect_out("repl.accept", 0, 0, 0, 8'h08, 8'h00, 2);
    tick(); expect_out("repl.reoffer", 1, 3, 0, 8'h08, 8'h00, 2);
    tick(); expect_out("repl.done", 0, 0, 0, 8'h00, 8'h00, 3);
    ready = 1'b0;

    // Mask: masked edge ignored; pending survives mask clear
    mask = 8'hFE; din = 8'h01;
    tick(); expect_out("mask.ign", 0, 0, 0, 8'h00, 8'h00, 3);
    tick(); expect_out("mask.ign2", 0, 0, 0, 8'h00, 8'h00, 3);
    mask = 8'hFF; din = 8'h00;
    tick(); expect_out("mask.pend", 0, 0, 0, 8'h01, 8'h00, 3);
    mask = 8'h00;
    tick(); expect_out("mask.offer", 1, 0, 0, 8'h01, 8'h00, 3);
    ready = 1'b1;
    tick(); expect_out("mask.done", 0, 0, 0, 8'h00, 8'h00, 4);

    // Randomized run against the model
    do_reset(8'($urandom));
    model_step(1'b1, din, mask, ovf_clr, ready);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      r_rst   = ($urandom_range(0, 599) == 0);
      flip    = 8'($urandom) & 8'($urandom) & 8'($urandom);
      din     = din ^ flip;
      mask    = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'hFF;
      ovf_clr = ($urandom_range(0, 11) == 0) ? 8'($urandom) : 8'h00;
      ready   = ((c % 200) < 40) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 3) != 0);
      reset   = r_rst;
      model_step(r_rst, din, mask, ovf_clr, ready);
      tick();
      chk("rnd.valid", 32'(evt_valid), 32'(m_offer));
      if (m_offer) begin
        chk("rnd.id", 32'(evt_id), 32'(m_id));
        chk("rnd.rise", 32'(evt_rise), 32'(m_rise));
      end
      chk("rnd.pending", 32'(pending), 32'(m_pend));
      chk("rnd.overflow", 32'(overflow), 32'(m_ovf));
      chk("rnd.count", 32'(evt_count), 32'(m_count));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
